// File: rtl/cache_refill_arbiter.sv
// Arbitrates the shared main-memory port between I-cache and D-cache refills,
// with an optional dirty-line write-back ahead of a D-side fill.
module cache_refill_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_req,
    input  logic [ADDR_W-1:0]        i_addr,
    output logic [DATA_W-1:0]        i_rdata,
    output logic                     i_rvalid,
    output logic [$clog2(WORDS)-1:0] i_word,
    output logic                     i_done,
    input  logic                     d_req,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic                     d_dirty,
    input  logic [ADDR_W-1:0]        d_wbaddr,
    input  logic [DATA_W-1:0]        d_wdata,
    output logic [DATA_W-1:0]        d_rdata,
    output logic                     d_rvalid,
    output logic [$clog2(WORDS)-1:0] d_word,
    output logic                     d_done,
    output logic                     grant_d,
    output logic                     busy,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack
);

    localparam int                WORD_W    = $clog2(WORDS);
    localparam int                BYTE_SH   = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(WORDS * (DATA_W / 8) - 1);
    localparam logic [WORD_W-1:0] CNT_LAST  = WORD_W'(WORDS - 1);
    localparam logic [WORD_W-1:0] CNT_ONE   = WORD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WORD_W-1:0]   r_cnt;
    logic                r_grant_d;
    logic [ADDR_W-1:0]   r_fill_base;
    logic [ADDR_W-1:0]   r_wb_base;
    logic                w_any_req;
    logic                w_pick_d;
    logic                w_last_ack;
    logic [ADDR_W-1:0]   w_off;

    // r_grant_d doubles as the round-robin history: on a tie the side that did not go last wins.
    assign w_any_req  = i_req | d_req;
    assign w_pick_d   = d_req & (~i_req | ~r_grant_d);
    assign w_last_ack = mem_ack & (r_cnt == CNT_LAST);
    assign w_off      = ADDR_W'(r_cnt) << BYTE_SH;
    assign grant_d    = r_grant_d;

    // State, word counter, grant history and latched line bases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= {WORD_W{1'b0}};
            r_grant_d   <= 1'b0;
            r_fill_base <= {ADDR_W{1'b0}};
            r_wb_base   <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_d   <= w_pick_d;
                        r_cnt       <= {WORD_W{1'b0}};
                        r_fill_base <= (w_pick_d ? d_addr : i_addr) & LINE_MASK;
                        r_wb_base   <= d_wbaddr & LINE_MASK;
                    end
                end
                // The counter wraps naturally, so the last write-back ack leaves it at word 0 for the fill.
                S_WB, S_FILL: begin
                    if (mem_ack) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Next-state and output decode; the non-granted side always sees zeros.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != S_IDLE);
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = {ADDR_W{1'b0}};
        mem_wdata   = {DATA_W{1'b0}};
        i_rdata     = {DATA_W{1'b0}};
        i_rvalid    = 1'b0;
        i_word      = {WORD_W{1'b0}};
        i_done      = 1'b0;
        d_rdata     = {DATA_W{1'b0}};
        d_rvalid    = 1'b0;
        d_word      = {WORD_W{1'b0}};
        d_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = (w_pick_d && d_dirty) ? S_WB : S_FILL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_wb_base | w_off;
                mem_wdata = d_wdata;
                d_word    = r_cnt;
                if (w_last_ack) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = r_fill_base | w_off;
                if (r_grant_d) begin
                    d_rvalid = mem_ack;
                    d_rdata  = mem_rdata;
                    d_word   = r_cnt;
                end else begin
                    i_rvalid = mem_ack;
                    i_rdata  = mem_rdata;
                    i_word   = r_cnt;
                end
                if (w_last_ack) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_DONE: begin
                i_done      = ~r_grant_d;
                d_done      = r_grant_d;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Randomised and directed checks of cache_refill_arbiter against a transaction-level
// model: each grant expands into a list of expected memory operations plus a done marker.
module tb_cache_refill_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int WORDS = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_dirty = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0, d_wbaddr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    i_word, d_word;
    logic          i_rvalid, i_done, d_rvalid, d_done, grant_d, busy, mem_req, mem_we;

    always #5 clk = ~clk;

    cache_refill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WORDS)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_word(i_word), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_dirty(d_dirty), .d_wbaddr(d_wbaddr),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_word(d_word),
        .d_done(d_done), .grant_d(grant_d), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // kind: 0 = write-back word, 1 = fill word, 2 = done pulse
    typedef struct {
        int          kind;
        logic [31:0] addr;
        int          idx;
    } op_t;

    op_t q[$];
    bit  m_last_d = 1'b0;
    int  n_cmp = 0, n_fail = 0;
    bit  seen_i = 1'b0, seen_d = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_i_rvalid"}, i_rvalid, 0);
        chk({tag, "_d_rvalid"}, d_rvalid, 0);
        chk({tag, "_i_done"}, i_done, 0);
        chk({tag, "_d_done"}, d_done, 0);
        chk({tag, "_i_word"}, i_word, 0);
        chk({tag, "_d_word"}, d_word, 0);
        chk({tag, "_grant_d"}, grant_d, 0);
    endtask

    task automatic push_txn(input bit is_d, input bit dirty, input logic [31:0] fa,
                            input logic [31:0] wa);
        op_t         o;
        logic [31:0] mask;
        mask = ~(32'(WORDS * DW / 8) - 32'd1);
        if (is_d && dirty) begin
            for (int k = 0; k < WORDS; k++) begin
                o.kind = 0; o.addr = (wa & mask) + 32'(k * 4); o.idx = k;
                q.push_back(o);
            end
        end
        for (int k = 0; k < WORDS; k++) begin
            o.kind = 1; o.addr = (fa & mask) + 32'(k * 4); o.idx = k;
            q.push_back(o);
        end
        o.kind = 2; o.addr = 32'd0; o.idx = 0;
        q.push_back(o);
    endtask

    // Mid-cycle: compare DUT against the model, then advance the model across the coming edge.
    task automatic settle();
        op_t f;
        bit  pick_d, exp_rv;
        @(negedge clk);
        seen_i = i_done;
        seen_d = d_done;
        if (!reset_n) begin
            check_zero("rst");
            q.delete();
            m_last_d = 1'b0;
        end else if (q.size() == 0) begin
            chk("idle_busy", busy, 0);
            chk("idle_mem_req", mem_req, 0);
            chk("idle_i_rvalid", i_rvalid, 0);
            chk("idle_d_rvalid", d_rvalid, 0);
            chk("idle_i_done", i_done, 0);
            chk("idle_d_done", d_done, 0);
            chk("idle_grant_d", grant_d, m_last_d);
            if (i_req || d_req) begin
                pick_d   = d_req && (!i_req || !m_last_d);
                m_last_d = pick_d;
                push_txn(pick_d, d_dirty, pick_d ? d_addr : i_addr, d_wbaddr);
            end
        end else begin
            f = q[0];
            chk("busy", busy, 1);
            chk("grant_d", grant_d, m_last_d);
            if (f.kind == 2) begin
                chk("done_mem_req", mem_req, 0);
                chk("i_done", i_done, !m_last_d);
                chk("d_done", d_done, m_last_d);
                chk("done_i_rvalid", i_rvalid, 0);
                chk("done_d_rvalid", d_rvalid, 0);
                void'(q.pop_front());
            end else begin
                exp_rv = (f.kind == 1) && mem_ack;
                chk("mem_req", mem_req, 1);
                chk("mem_we", mem_we, f.kind == 0);
                chk("mem_addr", mem_addr, f.addr);
                if (f.kind == 0) chk("mem_wdata", mem_wdata, d_wdata);
                chk("i_rvalid", i_rvalid, !m_last_d && exp_rv);
                chk("d_rvalid", d_rvalid, m_last_d && exp_rv);
                chk("i_word", i_word, m_last_d ? 0 : f.idx);
                chk("d_word", d_word, m_last_d ? f.idx : 0);
                if (exp_rv) chk("rdata", m_last_d ? d_rdata : i_rdata, mem_rdata);
                chk("xfer_i_done", i_done, 0);
                chk("xfer_d_done", d_done, 0);
                if (mem_ack) void'(q.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = $urandom;
        d_wdata   = $urandom;
    endtask

    task automatic do_reset();
        tick();
        reset_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_dirty = 1'b0; mem_ack = 1'b1;
        settle();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic run_until_done(input string nm);
        int c = 0;
        while (!(seen_i || seen_d) && c < 200) begin
            tick(); settle(); c++;
        end
        chk({nm, "_timeout"}, seen_i || seen_d, 1);
        tick();
        i_req = 1'b0; d_req = 1'b0;
        settle();
    endtask

    task automatic drive_random();
        reset_n = 1'b1;
        mem_ack = ($urandom_range(0, 2) != 0);
        if (seen_i) i_req = 1'b0;
        else if (!i_req) begin
            if ($urandom_range(0, 4) == 0) begin i_req = 1'b1; i_addr = $urandom; end
        end else if ($urandom_range(0, 59) == 0) i_req = 1'b0;
        if (seen_d) d_req = 1'b0;
        else if (!d_req) begin
            if ($urandom_range(0, 4) == 0) begin
                d_req = 1'b1; d_addr = $urandom; d_wbaddr = $urandom;
                d_dirty = 1'($urandom_range(0, 1));
            end
        end else if ($urandom_range(0, 59) == 0) d_req = 1'b0;
        if ($urandom_range(0, 299) == 0) begin
            #2 reset_n = 1'b0;
            #1 check_zero("rnd_async");
        end
    endtask

    initial begin
        logic [3:0]  ord;
        logic [31:0] pa;
        bit          pwait;
        int          ndone, cyc, nrv, donecyc;

        // 1: clean I fill, ack always high
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_104C; mem_ack = 1'b1;
        settle();
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk("t1_addr", mem_addr, 32'h1040 + 32'(k * 4));
            chk("t1_rvalid", i_rvalid, 1);
            chk("t1_word", i_word, k);
            chk("t1_d_rvalid", d_rvalid, 0);
        end
        tick(); settle();
        chk("t1_i_done", i_done, 1);
        chk("t1_d_done", d_done, 0);
        tick(); i_req = 1'b0; settle();
        chk("t1_idle", busy, 0);

        // 2: dirty D with write-back
        do_reset();
        d_req = 1'b1; d_dirty = 1'b1; d_wbaddr = 32'h2000; d_addr = 32'h3008; mem_ack = 1'b1;
        settle();
        for (int k = 0; k < 4; k++) begin
            tick(); d_wdata = 32'hA5A5_0000 + 32'(k); settle();
            chk("t2_we", mem_we, 1);
            chk("t2_wb_addr", mem_addr, 32'h2000 + 32'(k * 4));
            chk("t2_wdata", mem_wdata, 32'hA5A5_0000 + 32'(k));
            chk("t2_wb_word", d_word, k);
        end
        for (int k = 0; k < 4; k++) begin
            tick(); settle();
            chk("t2_rd", mem_we, 0);
            chk("t2_fill_addr", mem_addr, 32'h3000 + 32'(k * 4));
            chk("t2_rvalid", d_rvalid, 1);
        end
        tick(); settle();
        chk("t2_d_done", d_done, 1);
        chk("t2_i_done", i_done, 0);
        tick(); d_req = 1'b0; d_dirty = 1'b0; settle();

        // 3: tie out of reset, requests re-raised after each done
        do_reset();
        i_req = 1'b1; d_req = 1'b1; d_dirty = 1'b0; i_addr = 32'h100; d_addr = 32'h200;
        ord = 4'd0; ndone = 0; cyc = 0;
        settle();
        while (ndone < 4 && cyc < 200) begin
            tick();
            i_req = !seen_i; d_req = !seen_d;
            settle();
            if (seen_i) begin ord = {ord[2:0], 1'b0}; ndone++; end
            if (seen_d) begin ord = {ord[2:0], 1'b1}; ndone++; end
            cyc++;
        end
        chk("t3_done_count", ndone, 4);
        chk("t3_order", ord, 4'b1010);
        tick(); i_req = 1'b0; d_req = 1'b0; settle();

        // 4: three wait states per word
        do_reset();
        i_req = 1'b1; i_addr = 32'h0000_4444; mem_ack = 1'b0;
        settle();
        pwait = 1'b0; pa = '0; cyc = 0; nrv = 0; donecyc = -1;
        while (donecyc < 0 && cyc < 100) begin
            tick(); mem_ack = (cyc % 4 == 3); settle();
            if (pwait) begin
                chk("t4_hold_addr", mem_addr, pa);
                chk("t4_hold_req", mem_req, 1);
            end
            pwait = mem_req && !mem_ack;
            pa = mem_addr;
            if (i_rvalid) nrv++;
            if (seen_i) donecyc = cyc;
            cyc++;
        end
        chk("t4_rvalids", nrv, 4);
        chk("t4_done_cycle", donecyc, 16);
        tick(); i_req = 1'b0; mem_ack = 1'b1; settle();

        // 5: asynchronous reset during the second write-back word
        do_reset();
        d_req = 1'b1; d_dirty = 1'b1; d_wbaddr = 32'h2000; d_addr = 32'h3008; mem_ack = 1'b1;
        settle();
        tick(); settle();
        tick(); mem_ack = 1'b0;
        chk("t5_pre_addr", mem_addr, 32'h2004);
        #2 reset_n = 1'b0;
        #1 check_zero("t5_async");
        settle();
        tick(); reset_n = 1'b1; mem_ack = 1'b1; settle();
        tick(); settle();
        chk("t5_restart_we", mem_we, 1);
        chk("t5_restart_addr", mem_addr, 32'h2000);
        chk("t5_restart_word", d_word, 0);
        run_until_done("t5");

        // 6: I request withdrawn during fill word 2
        do_reset();
        i_req = 1'b1; i_addr = 32'h5000; mem_ack = 1'b1;
        settle();
        tick(); settle();
        tick(); settle();
        tick(); i_req = 1'b0; settle();
        chk("t6_w2_rvalid", i_rvalid, 1);
        chk("t6_w2_word", i_word, 2);
        tick(); settle();
        tick(); settle();
        chk("t6_i_done", i_done, 1);
        tick(); settle();
        chk("t6_idle", busy, 0);

        // randomised traffic with occasional asynchronous resets
        do_reset();
        settle();
        for (int n = 0; n < 4000; n++) begin
            tick();
            drive_random();
            settle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
